// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_pkg
// Description : Shared command and state encodings for the CAM lookup controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2,
        OP_RSVD   = 2'd3
    } cam_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MATCH = 2'd1,
        ST_RESP  = 2'd2
    } cam_state_t;

endpackage
`default_nettype wire

// File: rtl/cam_prio_onehot.sv
`default_nettype none
// ============================================================================
// Module      : cam_prio_onehot
// Description : Isolates the lowest set bit of a vector as a one-hot word.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_prio_onehot #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [WIDTH-1:0] o_onehot
);

    // Two's-complement trick: v & -v keeps only the lowest set bit.
    assign o_onehot = i_vec & (~i_vec + WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/cam_lookup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cam_lookup_ctrl
// Description : Small register-based CAM with lookup/insert/delete commands.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_lookup_ctrl
    import cam_pkg::*;
#(
    parameter int KEY_WIDTH  = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DATA_LINES = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [1:0]                        req_op,
    input  logic [KEY_WIDTH-1:0]              req_key,
    input  logic [DATA_WIDTH-1:0]             req_data,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_hit,
    output logic                              rsp_err,
    output logic [DATA_LINES-1:0]             rsp_sel,
    output logic [DATA_WIDTH-1:0]             rsp_data,
    output logic [$clog2(DATA_LINES+1)-1:0]   occupancy,
    output logic                              full
);

    localparam int c_occ_w = $clog2(DATA_LINES + 1);

    cam_state_t                r_state;
    cam_op_t                   r_op;
    logic [KEY_WIDTH-1:0]      r_key;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [KEY_WIDTH-1:0]      r_keys [DATA_LINES];
    logic [DATA_WIDTH-1:0]     r_vals [DATA_LINES];
    logic [DATA_LINES-1:0]     r_valid;

    logic                      r_req_ready;
    logic                      r_rsp_valid;
    logic                      r_rsp_hit;
    logic                      r_rsp_err;
    logic [DATA_LINES-1:0]     r_rsp_sel;
    logic [DATA_WIDTH-1:0]     r_rsp_data;

    logic [DATA_LINES-1:0]     w_match_vec;
    logic [DATA_LINES-1:0]     w_match_oh;
    logic [DATA_LINES-1:0]     w_free_oh;
    logic [DATA_WIDTH-1:0]     w_sel_data;
    logic [c_occ_w-1:0]        w_occ;
    logic                      w_hit;
    logic                      w_full;

    generate
        for (genvar g = 0; g < DATA_LINES; g++) begin : g_match
            assign w_match_vec[g] = r_valid[g] && (r_keys[g] == r_key);
        end
    endgenerate

    cam_prio_onehot #(.WIDTH(DATA_LINES)) u_match_prio (
        .i_vec    (w_match_vec),
        .o_onehot (w_match_oh)
    );

    cam_prio_onehot #(.WIDTH(DATA_LINES)) u_free_prio (
        .i_vec    (~r_valid),
        .o_onehot (w_free_oh)
    );

    // Occupancy is derived from the valid bits so it tracks them on the same edge.
    always_comb begin
        w_sel_data = '0;
        w_occ      = '0;
        for (int i = 0; i < DATA_LINES; i++) begin
            w_sel_data = w_sel_data | (r_vals[i] & {DATA_WIDTH{w_match_oh[i]}});
            w_occ      = w_occ + c_occ_w'(r_valid[i]);
        end
    end

    assign w_hit  = |w_match_vec;
    assign w_full = (w_occ == c_occ_w'(DATA_LINES));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_valid     <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_sel   <= '0;
            r_rsp_data  <= '0;
            r_op        <= OP_LOOKUP;
            r_key       <= '0;
            r_data      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op        <= cam_op_t'(req_op);
                        r_key       <= req_key;
                        r_data      <= req_data;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_MATCH;
                    end
                end
                ST_MATCH: begin
                    r_state     <= ST_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_hit   <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_sel   <= '0;
                    r_rsp_data  <= '0;
                    case (r_op)
                        OP_LOOKUP: begin
                            r_rsp_hit  <= w_hit;
                            r_rsp_sel  <= w_match_oh;
                            r_rsp_data <= w_sel_data;
                        end
                        OP_INSERT: begin
                            if (w_hit) begin
                                for (int i = 0; i < DATA_LINES; i++)
                                    if (w_match_oh[i]) r_vals[i] <= r_data;
                                r_rsp_hit <= 1'b1;
                                r_rsp_sel <= w_match_oh;
                            end else if (!w_full) begin
                                for (int i = 0; i < DATA_LINES; i++) begin
                                    if (w_free_oh[i]) begin
                                        r_keys[i]  <= r_key;
                                        r_vals[i]  <= r_data;
                                        r_valid[i] <= 1'b1;
                                    end
                                end
                                r_rsp_sel <= w_free_oh;
                            end else begin
                                r_rsp_err <= 1'b1;
                            end
                        end
                        OP_DELETE: begin
                            r_valid   <= r_valid & ~w_match_oh;
                            r_rsp_hit <= w_hit;
                            r_rsp_sel <= w_match_oh;
                        end
                        default: r_rsp_err <= 1'b1;
                    endcase
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_err   = r_rsp_err;
    assign rsp_sel   = r_rsp_sel;
    assign rsp_data  = r_rsp_data;
    assign occupancy = w_occ;
    assign full      = w_full;

endmodule
`default_nettype wire

// File: tb/tb_cam_lookup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_lookup_ctrl
// Description : Directed self-checking bench for cam_lookup_ctrl (4 lines).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_lookup_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_key;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic        rsp_err;
    logic [3:0]  rsp_sel;
    logic [31:0] rsp_data;
    logic [2:0]  occupancy;
    logic        full;

    int n_checks = 0;
    int n_fail   = 0;

    cam_lookup_ctrl #(
        .KEY_WIDTH  (16),
        .DATA_WIDTH (32),
        .DATA_LINES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_key   (req_key),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hit   (rsp_hit),
        .rsp_err   (rsp_err),
        .rsp_sel   (rsp_sel),
        .rsp_data  (rsp_data),
        .occupancy (occupancy),
        .full      (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Issue one command and leave the bench one cycle into RESP with rsp_ready low.
    task automatic issue(input logic [1:0] op, input logic [15:0] key, input logic [31:0] data);
        int n;
        req_valid = 1'b1;
        req_op    = op;
        req_key   = key;
        req_data  = data;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_before_accept", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rsp_valid_in_match", rsp_valid, 0);
        check("req_ready_in_match", req_ready, 0);
        @(posedge clk); #1;
        check("rsp_valid_in_resp", rsp_valid, 1);
    endtask

    task automatic expect_rsp(input string tag, input logic hit, input logic err,
                              input logic [3:0] sel, input logic [31:0] data,
                              input logic [2:0] occ, input logic fl);
        check({tag, ".hit"},  rsp_hit,   hit);
        check({tag, ".err"},  rsp_err,   err);
        check({tag, ".sel"},  rsp_sel,   sel);
        check({tag, ".data"}, rsp_data,  data);
        check({tag, ".occ"},  occupancy, occ);
        check({tag, ".full"}, full,      fl);
    endtask

    task automatic complete();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_after_hs", rsp_valid, 0);
        check("req_ready_after_hs", req_ready, 1);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_key   = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset.req_ready", req_ready, 1);
        check("reset.rsp_valid", rsp_valid, 0);
        expect_rsp("reset", 0, 0, 4'b0000, 32'h0, 3'd0, 0);

        // Insert to empty table, then look it up.
        issue(2'd1, 16'h0011, 32'hAAAA0001);
        expect_rsp("ins_0011", 0, 0, 4'b0001, 32'h0, 3'd1, 0);
        complete();
        issue(2'd0, 16'h0011, 32'h0);
        expect_rsp("lkp_0011", 1, 0, 4'b0001, 32'hAAAA0001, 3'd1, 0);
        complete();

        // Overwrite an existing key.
        issue(2'd1, 16'h0011, 32'h55550002);
        expect_rsp("ovw_0011", 1, 0, 4'b0001, 32'h0, 3'd1, 0);
        complete();
        issue(2'd0, 16'h0011, 32'h0);
        expect_rsp("lkp_ovw", 1, 0, 4'b0001, 32'h55550002, 3'd1, 0);
        complete();

        // Fill the table.
        issue(2'd1, 16'h0022, 32'h22220002);
        expect_rsp("ins_0022", 0, 0, 4'b0010, 32'h0, 3'd2, 0);
        complete();
        issue(2'd1, 16'h0033, 32'h33330003);
        expect_rsp("ins_0033", 0, 0, 4'b0100, 32'h0, 3'd3, 0);
        complete();
        issue(2'd1, 16'h0044, 32'h44440004);
        expect_rsp("ins_0044", 0, 0, 4'b1000, 32'h0, 3'd4, 1);
        complete();

        // Insert into full table is refused.
        issue(2'd1, 16'h0099, 32'h99990009);
        expect_rsp("ins_full", 0, 1, 4'b0000, 32'h0, 3'd4, 1);
        complete();
        issue(2'd0, 16'h0099, 32'h0);
        expect_rsp("lkp_0099", 0, 0, 4'b0000, 32'h0, 3'd4, 1);
        complete();

        // Delete entry 1 and reuse its slot.
        issue(2'd2, 16'h0022, 32'h0);
        expect_rsp("del_0022", 1, 0, 4'b0010, 32'h0, 3'd3, 0);
        complete();
        issue(2'd1, 16'h0055, 32'h55550005);
        expect_rsp("ins_0055", 0, 0, 4'b0010, 32'h0, 3'd4, 1);
        complete();
        issue(2'd2, 16'h0777, 32'h0);
        expect_rsp("del_miss", 0, 0, 4'b0000, 32'h0, 3'd4, 1);
        complete();

        // Reserved opcode.
        issue(2'd3, 16'h0033, 32'h12345678);
        expect_rsp("rsvd", 0, 1, 4'b0000, 32'h0, 3'd4, 1);
        complete();

        // Back-pressure: response must hold while rsp_ready is low.
        issue(2'd0, 16'h0033, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("stall.rsp_valid", rsp_valid, 1);
            check("stall.req_ready", req_ready, 0);
            expect_rsp("stall", 1, 0, 4'b0100, 32'h33330003, 3'd4, 1);
            @(posedge clk); #1;
        end
        complete();

        // Free a slot, then reset while an insert sits in MATCH.
        issue(2'd2, 16'h0011, 32'h0);
        expect_rsp("del_0011", 1, 0, 4'b0001, 32'h0, 3'd3, 0);
        complete();
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_key   = 16'h0ABC;
        req_data  = 32'h0ABC0ABC;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_match.req_ready", req_ready, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_match.req_ready", req_ready, 1);
        check("rst_match.rsp_valid", rsp_valid, 0);
        expect_rsp("rst_match", 0, 0, 4'b0000, 32'h0, 3'd0, 0);
        issue(2'd0, 16'h0ABC, 32'h0);
        expect_rsp("lkp_after_rst", 0, 0, 4'b0000, 32'h0, 3'd0, 0);
        complete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cam_lookup_ctrl.md
CAM_LOOKUP_CTRL -- requirements
Module: cam_lookup_ctrl

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 16, key width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, stored value width.
REQ-003 SHALL have parameter DATA_LINES, default 4, number of CAM entries (>=2).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  command present.
REQ-007 SHALL have port req_ready  output  1  controller accepts command.
REQ-008 SHALL have port req_op  input  2  0=LOOKUP, 1=INSERT, 2=DELETE, 3=reserved.
REQ-009 SHALL have port req_key  input  KEY_WIDTH  search/insert/delete key.
REQ-010 SHALL have port req_data  input  DATA_WIDTH  value for INSERT; ignored otherwise.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-013 SHALL have port rsp_hit  output  1  key matched a valid entry.
REQ-014 SHALL have port rsp_err  output  1  INSERT refused (full) or reserved op.
REQ-015 SHALL have port rsp_sel  output  DATA_LINES  one-hot entry touched; all-zero if none.
REQ-016 SHALL have port rsp_data  output  DATA_WIDTH  LOOKUP value; zero on miss or non-LOOKUP.
REQ-017 SHALL have port occupancy  output  $clog2(DATA_LINES+1)  count of valid entries.
REQ-018 SHALL have port full  output  1  occupancy == DATA_LINES.

Function
REQ-019 SHALL implement FSM IDLE -> MATCH -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-020 SHALL latch op/key/data on req_valid&&req_ready and enter MATCH next cycle.
REQ-021 SHALL in MATCH form match vector = valid[i] && key[i]==latched key, reduced to lowest-index one-hot.
REQ-022 SHALL in MATCH select lowest-index free entry (valid=0) as one-hot insert target.
REQ-023 SHALL select data via one-hot AND-OR reduction of entries by rsp_sel; all-zero sel yields zero.
REQ-024 SHALL at end of MATCH commit: INSERT hit -> overwrite data, hit=1; INSERT miss, not full -> write key/data to free entry, set valid, hit=0; INSERT miss, full -> no write, err=1.
REQ-025 SHALL for DELETE hit clear valid of matched entry (hit=1); DELETE miss -> no change, hit=0.
REQ-026 SHALL for reserved op make no change, err=1, hit=0, rsp_sel=0.
REQ-027 SHALL register response fields at end of MATCH; rsp_valid=1 throughout RESP; accept edge N -> rsp_valid first seen N+2.
REQ-028 SHALL hold all rsp_* stable while rsp_valid&&!rsp_ready; leave RESP on rsp_valid&&rsp_ready.
REQ-029 SHALL update occupancy/full in same cycle valid bits change; never exceed DATA_LINES nor underflow.
REQ-030 SHALL never create duplicate valid keys.

Reset
REQ-031 SHALL on reset clear all valid bits, enter IDLE, drive req_ready=1 from next cycle, rsp_valid=0, rsp_hit=0, rsp_err=0, rsp_sel=0, rsp_data=0, occupancy=0, full=0.
REQ-032 SHALL abandon any in-flight command on reset with no entry write; key/data storage need not be cleared.

Structure
REQ-033 SHALL place op encoding enum (cam_op_t) and FSM state enum (cam_state_t) in shared package cam_pkg.
REQ-034 SHALL use one sub-module, cam_prio_onehot (vector -> lowest-set one-hot), instanced for match and free selection.

Verification (DATA_LINES=4, KEY_WIDTH=16, DATA_WIDTH=32)
REQ-035 SHALL cover: reset; INSERT 0x0011/0xAAAA0001 -> hit=0, err=0, rsp_sel=0001, occupancy=1; LOOKUP 0x0011 -> hit=1, rsp_data=0xAAAA0001, rsp_valid at N+2.
REQ-036 SHALL cover: INSERT existing 0x0011 with 0x55550002 -> hit=1, rsp_sel=0001, occupancy unchanged; LOOKUP returns 0x55550002.
REQ-037 SHALL cover: fill 4 keys, INSERT fifth 0x0099 -> err=1, rsp_sel=0000, full=1; LOOKUP 0x0099 -> hit=0, rsp_data=0.
REQ-038 SHALL cover: DELETE entry 1 key, then INSERT new key -> rsp_sel=0010, occupancy 3 -> 4; DELETE absent key -> hit=0, no occupancy change.
REQ-039 SHALL cover: rsp_ready low 5 cycles -> rsp_* stable, req_ready=0; reset asserted in MATCH -> no write, occupancy=0, IDLE next cycle.
